alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: DATA_W, default 32, operand width; only 32 is supported, result width is 2*DATA_W.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 input_a  input  32  operand A; two's complement where signed.
REQ-005 input_b  input  32  operand B; shift/rotate amount taken from input_b[4:0].
REQ-006 opcode  input  5  operation select.
REQ-007 ALU_result  output  64  registered result; [31:0] low word, [63:32] high word.

Function
REQ-008 ALU_result SHALL be registered: inputs sampled at rising edge N appear on ALU_result after edge N, one-cycle latency, no handshake.
REQ-009 ALU_result SHALL hold its value between edges; every non-reset edge reloads it from the current inputs.
REQ-010 For all 32-bit operations (opcodes 0-8, 11, 12) the high word SHALL be 0 and the low word the 32-bit result.
REQ-011 Opcode 0 ADD: A+B modulo 2^32, carry discarded.
REQ-012 Opcode 1 SUB: A-B modulo 2^32.
REQ-013 Opcode 2 AND and opcode 3 OR: bitwise.
REQ-014 Opcode 4 SHR: logical right shift of A by B[4:0], zero fill.
REQ-015 Opcode 5 SHRA: arithmetic right shift of A by B[4:0], sign fill.
REQ-016 Opcode 6 SHL: left shift of A by B[4:0], zero fill.
REQ-017 Opcode 7 ROR and opcode 8 ROL: rotate A right/left by B[4:0]; amount 0 returns A.
REQ-018 Opcode 9 MUL: signed 32x32 product; full 64-bit product on ALU_result.
REQ-019 Opcode 10 DIV: signed A/B, quotient truncated toward zero in [31:0], remainder (sign of A) in [63:32].
REQ-020 DIV with B=0 SHALL yield quotient 0xFFFFFFFF and remainder A.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0.
REQ-022 Opcode 11 NEG: two's complement of A (B ignored). Opcode 12 NOT: bitwise inverse of A.
REQ-023 Opcodes 13-31 SHALL produce ALU_result = 0.
REQ-024 MUL and DIV SHALL complete combinationally within the single cycle; no busy/stall output.

Reset
REQ-025 When reset is high at a rising edge, ALU_result SHALL become 0 regardless of opcode/operands.
REQ-026 Reset SHALL take priority over computation; the first edge with reset low loads the result of the inputs present then.
REQ-027 No internal state other than ALU_result; reset mid-operation loses nothing else.

Configuration
REQ-028 Macro ALU_MULDIV_EN: when defined, opcodes 9 and 10 behave per REQ-018 to REQ-021.
REQ-029 When ALU_MULDIV_EN is undefined, multiplier and divider logic SHALL be absent and opcodes 9 and 10 SHALL produce ALU_result = 0; all other opcodes unchanged.

Verification
REQ-030 reset=1 one edge with A=2,B=3,op=0 -> ALU_result=0; release, next edge -> 0x0000000000000005.
REQ-031 A=2,B=3,op=1 -> 0x00000000FFFFFFFF; A=12,B=17,op=2 -> 0x0; A=17,B=20,op=3 -> 0x0000000000000015.
REQ-032 A=0x80000010,B=4: op4 -> 0x08000001, op5 -> 0xF8000001, op6 -> 0x00000100, op7 -> 0x08000001, op8 -> 0x00000108 (high word 0).
REQ-033 With ALU_MULDIV_EN: A=17,B=17,op=9 -> 0x121; A=-3,B=5,op=9 -> 0xFFFFFFFFFFFFFFF1; A=20,B=3,op=10 -> 0x0000000200000006; A=-7,B=2,op=10 -> high 0xFFFFFFFF, low 0xFFFFFFFD.
REQ-034 A=5,B=0,op=10 -> 0x00000005FFFFFFFF; without ALU_MULDIV_EN, op=9/10 -> 0.
REQ-035 A=17,op=11 -> 0x00000000FFFFFFEF; op=12 -> 0x00000000FFFFFFEE; op=20 -> 0; reset asserted while op changes -> result stays 0.

Source files
------------

// File: rtl/alu.sv
// ALU with a registered 64-bit result and one cycle of latency.
// Optional build macro: ALU_MULDIV_EN. When it is defined, opcodes 9 (MUL) and
// 10 (DIV) are implemented. When it is undefined, no multiplier or divider is
// built, and those two opcodes return zero.
// The result register is the only state. Reset is synchronous and active-high.

module alu #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     input_a,
    input  logic [DATA_W-1:0]     input_b,
    input  logic [4:0]            opcode,
    output logic [2*DATA_W-1:0]   ALU_result
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SHR  = 5'd4,
        OP_SHRA = 5'd5,
        OP_SHL  = 5'd6,
        OP_ROR  = 5'd7,
        OP_ROL  = 5'd8,
        OP_MUL  = 5'd9,
        OP_DIV  = 5'd10,
        OP_NEG  = 5'd11,
        OP_NOT  = 5'd12
    } opcode_e;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    logic [2*DATA_W-1:0] r_result;
    logic [2*DATA_W-1:0] w_next;
    opcode_e             w_op;
    logic [4:0]          w_shamt;
    logic [DATA_W-1:0]   w_sra;
    logic [2*DATA_W-1:0] w_rorWide;
    logic [2*DATA_W-1:0] w_rolWide;

    assign w_op    = opcode_e'(opcode);
    assign w_shamt = input_b[4:0];
    assign w_sra   = DATA_W'($signed(input_a) >>> w_shamt);

    // A rotate is a shift of A concatenated with itself. The wanted word is
    // then the low half (right rotate) or the high half (left rotate).
    assign w_rorWide = {input_a, input_a} >> w_shamt;
    assign w_rolWide = {input_a, input_a} << w_shamt;

`ifdef ALU_MULDIV_EN
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0]   w_absA;
    logic [DATA_W-1:0]   w_absB;
    logic [DATA_W-1:0]   w_divisor;
    logic [DATA_W-1:0]   w_uQuot;
    logic [DATA_W-1:0]   w_uRem;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic                w_divByZero;
    logic [2*DATA_W-1:0] w_divResult;

    // Multiplying the two sign-extended operands modulo 2^64 gives the full
    // signed 64-bit product.
    assign w_product = {{DATA_W{input_a[DATA_W-1]}}, input_a}
                     * {{DATA_W{input_b[DATA_W-1]}}, input_b};

    // The divide runs on unsigned magnitudes, and the signs are applied
    // afterwards. Read as unsigned, the magnitude of 0x80000000 is 2^31. So
    // 0x80000000 / -1 gives quotient 0x80000000 with no special case. A zero
    // divisor is replaced by 1 so that the divider never sees zero; the
    // divide-by-zero result is then selected separately.
    assign w_divByZero = (input_b == ZERO_WORD);
    assign w_absA      = input_a[DATA_W-1] ? (ZERO_WORD - input_a) : input_a;
    assign w_absB      = input_b[DATA_W-1] ? (ZERO_WORD - input_b) : input_b;
    assign w_divisor   = w_divByZero ? {{(DATA_W-1){1'b0}}, 1'b1} : w_absB;
    assign w_uQuot     = w_absA / w_divisor;
    assign w_uRem      = w_absA % w_divisor;
    assign w_quot      = (input_a[DATA_W-1] ^ input_b[DATA_W-1])
                       ? (ZERO_WORD - w_uQuot) : w_uQuot;
    assign w_rem       = input_a[DATA_W-1] ? (ZERO_WORD - w_uRem) : w_uRem;
    assign w_divResult = w_divByZero ? {input_a, {DATA_W{1'b1}}} : {w_rem, w_quot};
`endif

    // Select the next result for the current opcode.
    // Every 32-bit operation puts zero in the high word.
    always_comb begin
        w_next = '0;
        case (w_op)
            OP_ADD:  w_next = {ZERO_WORD, input_a + input_b};
            OP_SUB:  w_next = {ZERO_WORD, input_a - input_b};
            OP_AND:  w_next = {ZERO_WORD, input_a & input_b};
            OP_OR:   w_next = {ZERO_WORD, input_a | input_b};
            OP_SHR:  w_next = {ZERO_WORD, input_a >> w_shamt};
            OP_SHRA: w_next = {ZERO_WORD, w_sra};
            OP_SHL:  w_next = {ZERO_WORD, input_a << w_shamt};
            OP_ROR:  w_next = {ZERO_WORD, w_rorWide[DATA_W-1:0]};
            OP_ROL:  w_next = {ZERO_WORD, w_rolWide[2*DATA_W-1:DATA_W]};
`ifdef ALU_MULDIV_EN
            OP_MUL:  w_next = w_product;
            OP_DIV:  w_next = w_divResult;
`else
            OP_MUL:  w_next = '0;
            OP_DIV:  w_next = '0;
`endif
            OP_NEG:  w_next = {ZERO_WORD, ZERO_WORD - input_a};
            OP_NOT:  w_next = {ZERO_WORD, ~input_a};
            default: w_next = '0;
        endcase
    end

    // Result register. Reset wins over the computed value, and every other
    // rising edge reloads the register from the current inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
        end else begin
            r_result <= w_next;
        end
    end

    assign ALU_result = r_result;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu. The expected value is pushed to a scoreboard
// queue when stimulus is driven. It is popped and compared one edge later,
// when the registered result appears.

module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [4:0]  opcode;
    logic [63:0] ALU_result;

    int checks   = 0;
    int failures = 0;

    logic [63:0] expQ[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [63:0] exp;
    } vec_t;

    alu #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .input_a    (input_a),
        .input_b    (input_b),
        .opcode     (opcode),
        .ALU_result (ALU_result)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [4:0] op, logic [63:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.exp = exp;
        return v;
    endfunction

    // Reference model for the 32-bit operations. Shifts and rotates are built
    // bit by bit here, independently of how the design computes them.
    function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic [4:0] op);
        logic [31:0] r;
        int s;
        s = int'(b[4:0]);
        r = '0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i + s] : 1'b0;
            5'd5:  for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i + s] : a[31];
            5'd6:  for (int i = 0; i < 32; i++) r[i] = (i - s >= 0) ? a[i - s] : 1'b0;
            5'd7:  for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32];
            5'd8:  for (int i = 0; i < 32; i++) r[(i + s) % 32] = a[i];
            5'd11: r = 32'd0 - a;
            5'd12: r = ~a;
            default: r = '0;
        endcase
        return {32'd0, r};
    endfunction

    // Drive one set of inputs on the falling edge and push its expected
    // result. Then wait until just after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] op, input logic [63:0] exp);
        @(negedge clk);
        reset   = rst;
        input_a = a;
        input_b = b;
        opcode  = op;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] want;
        applyStimulus(1'b1, 32'd2, 32'd3, 5'd0, 64'd0);
        want = expQ.pop_front();
        checks++;
        if (ALU_result !== want) begin
            failures++;
            $display("[TB] FAIL reset_hold got=%h want=%h", ALU_result, want);
        end
        applyStimulus(1'b0, 32'd2, 32'd3, 5'd0, 64'h0000000000000005);
        want = expQ.pop_front();
        checks++;
        if (ALU_result !== want) begin
            failures++;
            $display("[TB] FAIL reset_release got=%h want=%h", ALU_result, want);
        end
    endtask

    task automatic test_logic();
        vec_t vs[$];
        logic [63:0] want;
        vs.push_back(mk(32'd2,  32'd3,  5'd1, 64'h00000000FFFFFFFF));
        vs.push_back(mk(32'd12, 32'd17, 5'd2, 64'h0));
        vs.push_back(mk(32'd17, 32'd20, 5'd3, 64'h0000000000000015));
        vs.push_back(mk(32'hFFFFFFFF, 32'd1, 5'd0, 64'h0));
        foreach (vs[i]) begin
            applyStimulus(1'b0, vs[i].a, vs[i].b, vs[i].op, vs[i].exp);
            want = expQ.pop_front();
            checks++;
            if (ALU_result !== want) begin
                failures++;
                $display("[TB] FAIL arith_logic_%0d op=%0d got=%h want=%h", i, vs[i].op, ALU_result, want);
            end
        end
    endtask

    task automatic test_shift();
        vec_t vs[$];
        logic [63:0] want;
        vs.push_back(mk(32'h80000010, 32'd4, 5'd4, 64'h0000000008000001));
        vs.push_back(mk(32'h80000010, 32'd4, 5'd5, 64'h00000000F8000001));
        vs.push_back(mk(32'h80000010, 32'd4, 5'd6, 64'h0000000000000100));
        vs.push_back(mk(32'h80000010, 32'd4, 5'd7, 64'h0000000008000001));
        vs.push_back(mk(32'h80000010, 32'd4, 5'd8, 64'h0000000000000108));
        vs.push_back(mk(32'h12345678, 32'hFFFFFFE0, 5'd7, 64'h0000000012345678));
        vs.push_back(mk(32'h12345678, 32'd0, 5'd8, 64'h0000000012345678));
        vs.push_back(mk(32'h80000000, 32'd31, 5'd5, 64'h00000000FFFFFFFF));
        vs.push_back(mk(32'h00000001, 32'd31, 5'd6, 64'h0000000080000000));
        foreach (vs[i]) begin
            applyStimulus(1'b0, vs[i].a, vs[i].b, vs[i].op, vs[i].exp);
            want = expQ.pop_front();
            checks++;
            if (ALU_result !== want) begin
                failures++;
                $display("[TB] FAIL shift_%0d op=%0d got=%h want=%h", i, vs[i].op, ALU_result, want);
            end
        end
    endtask

    task automatic test_unary();
        vec_t vs[$];
        logic [63:0] want;
        vs.push_back(mk(32'd17, 32'h55, 5'd11, 64'h00000000FFFFFFEF));
        vs.push_back(mk(32'd17, 32'h55, 5'd12, 64'h00000000FFFFFFEE));
        vs.push_back(mk(32'd17, 32'd3,  5'd20, 64'h0));
        vs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 64'h0));
        vs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 64'h0));
        foreach (vs[i]) begin
            applyStimulus(1'b0, vs[i].a, vs[i].b, vs[i].op, vs[i].exp);
            want = expQ.pop_front();
            checks++;
            if (ALU_result !== want) begin
                failures++;
                $display("[TB] FAIL unary_%0d op=%0d got=%h want=%h", i, vs[i].op, ALU_result, want);
            end
        end
    endtask

    task automatic test_muldiv();
        vec_t vs[$];
        logic [63:0] want;
`ifdef ALU_MULDIV_EN
        vs.push_back(mk(32'd17, 32'd17, 5'd9,  64'h0000000000000121));
        vs.push_back(mk(-32'sd3, 32'd5, 5'd9,  64'hFFFFFFFFFFFFFFF1));
        vs.push_back(mk(32'h80000000, 32'h80000000, 5'd9, 64'h4000000000000000));
        vs.push_back(mk(32'd20, 32'd3,  5'd10, 64'h0000000200000006));
        vs.push_back(mk(-32'sd7, 32'd2, 5'd10, 64'hFFFFFFFFFFFFFFFD));
        vs.push_back(mk(-32'sd7, -32'sd2, 5'd10, 64'hFFFFFFFF00000003));
        vs.push_back(mk(32'd7, -32'sd2, 5'd10, 64'h00000001FFFFFFFD));
        vs.push_back(mk(32'd5,  32'd0,  5'd10, 64'h00000005FFFFFFFF));
        vs.push_back(mk(32'h80000000, 32'hFFFFFFFF, 5'd10, 64'h0000000080000000));
`else
        vs.push_back(mk(32'd17, 32'd17, 5'd9,  64'h0));
        vs.push_back(mk(-32'sd3, 32'd5, 5'd9,  64'h0));
        vs.push_back(mk(32'd20, 32'd3,  5'd10, 64'h0));
        vs.push_back(mk(32'd5,  32'd0,  5'd10, 64'h0));
`endif
        foreach (vs[i]) begin
            applyStimulus(1'b0, vs[i].a, vs[i].b, vs[i].op, vs[i].exp);
            want = expQ.pop_front();
            checks++;
            if (ALU_result !== want) begin
                failures++;
                $display("[TB] FAIL muldiv_%0d op=%0d got=%h want=%h", i, vs[i].op, ALU_result, want);
            end
        end
    endtask

    // Checks that the result holds between edges: the inputs change on the
    // falling edge, and the output must not move before the next rising edge.
    task automatic test_hold();
        logic [63:0] want;
        applyStimulus(1'b0, 32'd100, 32'd23, 5'd0, 64'd123);
        want = expQ.pop_front();
        checks++;
        if (ALU_result !== want) begin
            failures++;
            $display("[TB] FAIL hold_load got=%h want=%h", ALU_result, want);
        end
        @(negedge clk);
        input_a = 32'hDEADBEEF;
        opcode  = 5'd12;
        #2;
        checks++;
        if (ALU_result !== 64'd123) begin
            failures++;
            $display("[TB] FAIL hold_between_edges got=%h want=%h", ALU_result, 64'd123);
        end
    endtask

    // Asserts reset while the opcode and operands keep changing. Every edge
    // must give 0, and the first edge after release must load the inputs
    // present at that edge.
    task automatic test_reset_midop();
        vec_t vs[$];
        logic [63:0] want;
        vs.push_back(mk(32'd17, 32'd0, 5'd11, 64'h0));
        vs.push_back(mk(32'd17, 32'd0, 5'd12, 64'h0));
        vs.push_back(mk(32'd17, 32'd5, 5'd9,  64'h0));
        vs.push_back(mk(32'd17, 32'd5, 5'd0,  64'h0));
        foreach (vs[i]) begin
            applyStimulus(1'b1, vs[i].a, vs[i].b, vs[i].op, vs[i].exp);
            want = expQ.pop_front();
            checks++;
            if (ALU_result !== want) begin
                failures++;
                $display("[TB] FAIL reset_midop_%0d op=%0d got=%h want=%h", i, vs[i].op, ALU_result, want);
            end
        end
        applyStimulus(1'b0, 32'd17, 32'd0, 5'd12, 64'h00000000FFFFFFEE);
        want = expQ.pop_front();
        checks++;
        if (ALU_result !== want) begin
            failures++;
            $display("[TB] FAIL reset_midop_release got=%h want=%h", ALU_result, want);
        end
    endtask

    // Back-to-back random operands on the 32-bit opcodes and on unused
    // opcodes, with one new operation every cycle.
    task automatic test_back_to_back();
        logic [4:0]  ops[12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd11, 5'd12, 5'd25};
        logic [31:0] a, b;
        logic [4:0]  op;
        logic [63:0] want;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = ops[$urandom_range(0, 11)];
            applyStimulus(1'b0, a, b, op, model(a, b, op));
            want = expQ.pop_front();
            checks++;
            if (ALU_result !== want) begin
                failures++;
                $display("[TB] FAIL b2b_%0d op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, ALU_result, want);
            end
        end
    endtask

    // Runs the scenario sequence and prints the summary line.
    initial begin
        reset   = 1'b1;
        input_a = '0;
        input_b = '0;
        opcode  = '0;
        test_reset();
        test_logic();
        test_shift();
        test_unary();
        test_muldiv();
        test_hold();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
